// File: rtl/multdiv_iter.sv
// rtl/multdiv_iter.sv - iterative signed 32-bit shift-add multiplier / restoring divider (optional MULTDIV_EARLY_DBZ_EN)
module multdiv_iter #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    state_t             start_state;
    logic [CW-1:0]      count;
    logic               op_mult;
    logic               res_sign;
    logic               b_zero;
    logic               div_ovf;
    logic [WIDTH:0]     mag_a;
    logic [WIDTH:0]     mag_b;
    logic [2*WIDTH-1:0] acc;

    logic               start;
    logic [WIDTH:0]     ext_a;
    logic [WIDTH:0]     ext_b;
    logic [WIDTH:0]     in_mag_a;
    logic [WIDTH:0]     in_mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   rem_sh;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quot_signed;
    logic               mul_ovf;

    assign start = ctrl_MULT | ctrl_DIV;

    // 33-bit magnitudes so that the most negative operand keeps its full value
    assign ext_a    = {data_operandA[WIDTH-1], data_operandA};
    assign ext_b    = {data_operandB[WIDTH-1], data_operandB};
    assign in_mag_a = data_operandA[WIDTH-1] ? -ext_a : ext_a;
    assign in_mag_b = data_operandB[WIDTH-1] ? -ext_b : ext_b;

    // Multiply step: low half holds the remaining multiplier bits
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? mag_a : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide step: upper half is the partial remainder, lower half the quotient
    assign rem_sh   = acc[2*WIDTH-2:WIDTH-1];
    assign trial    = {1'b0, rem_sh} - mag_b;
    assign div_next = trial[WIDTH] ? {rem_sh, acc[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_signed = res_sign ? -acc : acc;
    assign quot_signed = res_sign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign mul_ovf     = ~(&prod_signed[2*WIDTH-1:WIDTH-1]) & (|prod_signed[2*WIDTH-1:WIDTH-1]);

    always_comb begin
        start_state = RUN;
`ifdef MULTDIV_EARLY_DBZ_EN
        if (!ctrl_MULT && (data_operandB == '0)) begin
            start_state = FIX;
        end
`endif
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = start_state;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                RUN:     state_next = (count == CW'(ITER - 1)) ? FIX : RUN;
                FIX:     state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count          <= '0;
            op_mult        <= 1'b0;
            res_sign       <= 1'b0;
            b_zero         <= 1'b0;
            div_ovf        <= 1'b0;
            mag_a          <= '0;
            mag_b          <= '0;
            acc            <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            count    <= '0;
            op_mult  <= ctrl_MULT;
            res_sign <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            b_zero   <= (data_operandB == '0);
            div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
            mag_a    <= in_mag_a;
            mag_b    <= in_mag_b;
            acc      <= {{WIDTH{1'b0}}, (ctrl_MULT ? in_mag_b[WIDTH-1:0] : in_mag_a[WIDTH-1:0])};
        end else begin
            case (state)
                RUN: begin
                    acc   <= op_mult ? mul_next : div_next;
                    count <= count + CW'(1);
                end
                FIX: begin
                    if (op_mult) begin
                        data_result    <= prod_signed[WIDTH-1:0];
                        data_exception <= mul_ovf;
                    end else if (b_zero) begin
                        data_result    <= '0;
                        data_exception <= 1'b1;
                    end else if (div_ovf) begin
                        data_result    <= {1'b1, {(WIDTH-1){1'b0}}};
                        data_exception <= 1'b1;
                    end else begin
                        data_result    <= quot_signed;
                        data_exception <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy           = (state == RUN) || (state == FIX);
    assign data_resultRDY = (state == DONE);

endmodule
